// File: rtl/star_extent_finder.sv
// Star extent finder: probes a pixel memory outward from a seed to find the
// horizontal and vertical extent of a lit blob and its centre.
module star_extent_finder #(
    parameter int X_W       = 8,
    parameter int Y_W       = 8,
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int COL_W     = 3,
    parameter int THRESHOLD = 0,
    parameter int ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [X_W-1:0]    seed_x,
    input  logic [Y_W-1:0]    seed_y,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COL_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [X_W-1:0]    left,
    output logic [X_W-1:0]    right,
    output logic [Y_W-1:0]    top,
    output logic [Y_W-1:0]    bottom,
    output logic [X_W-1:0]    mid_x,
    output logic [Y_W-1:0]    mid_y
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEED  = 3'd1;
    localparam logic [2:0] RIGHT = 3'd2;
    localparam logic [2:0] LEFT  = 3'd3;
    localparam logic [2:0] DOWN  = 3'd4;
    localparam logic [2:0] UP    = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    localparam logic [X_W-1:0]    X_MAX = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]    Y_MAX = Y_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(IMG_W);
    localparam logic [COL_W-1:0]  TH    = COL_W'(THRESHOLD);

    logic [2:0]     state, state_n;
    logic           check, check_n;
    logic [X_W-1:0] sx, sx_n, px, px_n;
    logic [Y_W-1:0] sy, sy_n, py, py_n;
    logic [X_W-1:0] left_n, right_n, mid_x_n;
    logic [Y_W-1:0] top_n, bottom_n, mid_y_n;
    logic           valid_n;
    logic           adv;
    logic [2:0]     from;
    logic [X_W:0]   mx_sum;
    logic [Y_W:0]   my_sum;
    logic           lit;

    assign lit     = rd_data > TH;
    assign rd_en   = (state >= SEED) && (state <= UP) && !check;
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
    assign rd_addr = ADDR_W'(py) * ROW + ADDR_W'(px);

    always_comb begin
        state_n  = state;
        check_n  = check;
        sx_n     = sx;
        sy_n     = sy;
        px_n     = px;
        py_n     = py;
        left_n   = left;
        right_n  = right;
        top_n    = top;
        bottom_n = bottom;
        mid_x_n  = mid_x;
        mid_y_n  = mid_y;
        valid_n  = valid;
        adv      = 1'b0;
        from     = DONE;
        mx_sum   = '0;
        my_sum   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    sx_n     = seed_x;
                    sy_n     = seed_y;
                    px_n     = seed_x;
                    py_n     = seed_y;
                    left_n   = seed_x;
                    right_n  = seed_x;
                    mid_x_n  = seed_x;
                    top_n    = seed_y;
                    bottom_n = seed_y;
                    mid_y_n  = seed_y;
                    valid_n  = 1'b0;
                    check_n  = 1'b0;
                    state_n  = SEED;
                end
            end
            DONE: state_n = IDLE;
            default: begin
                if (!check) begin
                    check_n = 1'b1;
                end else begin
                    check_n = 1'b0;
                    case (state)
                        SEED: begin
                            if (lit) begin
                                valid_n = 1'b1;
                                adv     = 1'b1;
                                from    = RIGHT;
                            end else begin
                                state_n = DONE;
                            end
                        end
                        RIGHT: begin
                            if (lit) right_n = px;
                            if (lit && px < X_MAX) px_n = px + 1'b1;
                            else begin
                                adv  = 1'b1;
                                from = LEFT;
                            end
                        end
                        LEFT: begin
                            if (lit) left_n = px;
                            if (lit && px != '0) px_n = px - 1'b1;
                            else begin
                                adv  = 1'b1;
                                from = DOWN;
                            end
                        end
                        DOWN: begin
                            if (lit) bottom_n = py;
                            if (lit && py < Y_MAX) py_n = py + 1'b1;
                            else begin
                                adv  = 1'b1;
                                from = UP;
                            end
                        end
                        UP: begin
                            if (lit) top_n = py;
                            if (lit && py != '0) py_n = py - 1'b1;
                            else begin
                                adv  = 1'b1;
                                from = DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        // Skip any direction already at the image edge so no cycle is lost.
        if (adv) begin
            mx_sum = {1'b0, left_n} + {1'b0, right_n};
            my_sum = {1'b0, top_n} + {1'b0, bottom_n};
            if (from <= RIGHT && sx < X_MAX) begin
                state_n = RIGHT;
                px_n    = sx + 1'b1;
                py_n    = sy;
            end else if (from <= LEFT && sx != '0) begin
                state_n = LEFT;
                px_n    = sx - 1'b1;
                py_n    = sy;
            end else begin
                mid_x_n = mx_sum[X_W:1];
                if (from <= DOWN && sy < Y_MAX) begin
                    state_n = DOWN;
                    px_n    = mid_x_n;
                    py_n    = sy + 1'b1;
                end else if (from <= UP && sy != '0) begin
                    state_n = UP;
                    px_n    = mid_x_n;
                    py_n    = sy - 1'b1;
                end else begin
                    state_n = DONE;
                    mid_y_n = my_sum[Y_W:1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            check  <= 1'b0;
            sx     <= '0;
            sy     <= '0;
            px     <= '0;
            py     <= '0;
            left   <= '0;
            right  <= '0;
            top    <= '0;
            bottom <= '0;
            mid_x  <= '0;
            mid_y  <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_n;
            check  <= check_n;
            sx     <= sx_n;
            sy     <= sy_n;
            px     <= px_n;
            py     <= py_n;
            left   <= left_n;
            right  <= right_n;
            top    <= top_n;
            bottom <= bottom_n;
            mid_x  <= mid_x_n;
            mid_y  <= mid_y_n;
            valid  <= valid_n;
        end
    end

endmodule

// File: doc/star_extent_finder.md
STAR_EXTENT_FINDER -- requirements
Module: star_extent_finder

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): X_W, 8, x coordinate width; Y_W, 8, y coordinate width; IMG_W, 160, image width in pixels; IMG_H, 120, image height in pixels; COL_W, 3, pixel value width; THRESHOLD, 0, largest pixel value counted as dark; ADDR_W, 15, pixel memory address width (>= clog2(IMG_W*IMG_H)).
REQ-002 The block SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock, rising edge.
REQ-003 reset, in, 1, asynchronous active-high reset.
REQ-004 start, in, 1, one-cycle request to measure the star seeded at (seed_x, seed_y).
REQ-005 seed_x, in, X_W, seed column; seed_y, in, Y_W, seed row; both sampled with start.
REQ-006 rd_en, out, 1, pixel read strobe.
REQ-007 rd_addr, out, ADDR_W, pixel address, equal to y*IMG_W + x, computed unsigned.
REQ-008 rd_data, in, COL_W, pixel value, valid exactly one cycle after its rd_en.
REQ-009 busy, out, 1; done, out, 1, one-cycle completion pulse; valid, out, 1, seed was lit.
REQ-010 left, right, out, X_W; top, bottom, out, Y_W; mid_x, out, X_W; mid_y, out, Y_W; all are measured extents and centres.

Function
REQ-011 A pixel SHALL be lit when rd_data > THRESHOLD and dark otherwise.
REQ-012 Every probe SHALL take exactly 2 cycles: an ISSUE cycle (rd_en=1, rd_addr driven), then a CHECK cycle (rd_en=0, rd_data evaluated).
REQ-013 FSM states SHALL be IDLE, SEED, RIGHT, LEFT, DOWN, UP, DONE, each probing state containing an ISSUE/CHECK phase bit.
REQ-014 IDLE: start=1 SHALL latch the seed, clear the extents to the seed, set busy=1 on the next cycle, and enter SEED.
REQ-015 start while busy=1 SHALL be ignored.
REQ-016 SEED: probe (seed_x, seed_y); dark -> valid=0 and go to DONE; lit -> valid=1 and go to RIGHT.
REQ-017 RIGHT: probe x = seed_x+1, +2, ... on row seed_y; on a lit pixel set right=x and continue; on a dark pixel, or when the next x would exceed IMG_W-1, go to LEFT without probing further.
REQ-018 LEFT: probe x = seed_x-1, -2, ... down to 0; on a lit pixel set left=x; stop on a dark pixel or before x would go below 0; then latch mid_x and go to DOWN.
REQ-019 mid_x SHALL equal (left+right)>>1, with the sum formed at X_W+1 bits so it cannot overflow.
REQ-020 DOWN: probe y = seed_y+1, ... in column mid_x; update bottom on lit pixels; stop on a dark pixel or at IMG_H-1; then go to UP.
REQ-021 UP: probe y = seed_y-1, ... down to 0 in column mid_x; update top on lit pixels; stop on a dark pixel or at row 0; then latch mid_y = (top+bottom)>>1 (Y_W+1-bit sum) and go to DONE.
REQ-022 A scan direction already at the image boundary SHALL issue zero probes and leave that extent equal to the seed coordinate.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-024 Total latency SHALL be 2P+1 cycles from the start edge to the done cycle, where P is the number of probes issued.
REQ-025 All result outputs SHALL hold their values from done until the next accepted start.

Reset
REQ-026 While reset=1 the FSM SHALL be IDLE, and busy, done, valid, rd_en, rd_addr, left, right, top, bottom, mid_x and mid_y SHALL all be 0. This applies immediately, including mid-scan.
REQ-027 After reset is released, no output SHALL change until start is accepted.

Verification
REQ-028 IMG 6x6, lit block x1..3, y1..4, seed (2,2), start -> P=10, done at cycle 21, valid=1, left=1, right=3, top=1, bottom=4, mid_x=2, mid_y=2.
REQ-029 Dark seed (0,0) on a blank image -> exactly one probe at addr 0, done at cycle 3, valid=0, all extents 0.
REQ-030 Fully lit 6x6 image, seed (5,5) -> no RIGHT or DOWN probes, left=0, right=5, mid_x=2, top=0, bottom=5, mid_y=2, no rd_addr >= 36.
REQ-031 Scenario of REQ-028 with start re-pulsed at cycle 5 -> ignored, results identical to REQ-028.
REQ-032 Scenario of REQ-028 with reset asserted at cycle 8 -> all outputs 0 asynchronously; a new start after release produces the REQ-028 results.
REQ-033 Every rd_addr SHALL equal y*IMG_W+x of the probed pixel, and rd_en SHALL never be high on two consecutive cycles.
